pwm_ramp_ctrl: RTL and testbench

//   Sequences the duty/direction inputs of one motor pwm channel from signed speed commands.

---
 rtl/pwm_ramp_ctrl_pkg.sv | 33 +++
 rtl/pwm_ramp_ctrl_tick.sv | 27 ++
 rtl/pwm_ramp_ctrl.sv | 138 +++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared motor-control types and duty arithmetic helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pwm_ramp_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RAMP_DN = 2'd1,
        DEAD    = 2'd2
    } ramp_state_t;

    // Full-scale duty (100%) for an r-bit pwm resolution.
    function automatic logic [31:0] duty_full(input int unsigned r);
        return 32'(1) << r;
    endfunction

    // Move cur up by step, never past lim.
    function automatic logic [31:0] sat_up(input logic [31:0] cur,
                                           input logic [31:0] step,
                                           input logic [31:0] lim);
        logic [31:0] sum;
        sum = cur + step;
        return (sum > lim) ? lim : sum;
    endfunction

    // Move cur down by step, never below lim (no unsigned wrap).
    function automatic logic [31:0] sat_dn(input logic [31:0] cur,
                                           input logic [31:0] step,
                                           input logic [31:0] lim);
        return (cur < lim + step) ? lim : cur - step;
    endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_tick.sv
// Ramp-rate divider: one-clock tick every tick_div+1 clocks.
// Latency: tick asserts combinationally while the count equals tick_div.
// Backpressure: none; clr holds the count at zero and suppresses the tick.
module ramp_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [31:0] tick_div,
    output logic        tick
);

    logic [31:0] cnt;

    assign tick = !clr && (cnt == tick_div);

    // Free-running counter; a live tick_div below the count wraps it to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || (cnt >= tick_div)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'(1);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Slews pwm duty toward a signed speed command; reversals ramp to zero and wait dead time.
// Latency: duty/dir registered; first duty change at most tick_div+2 clocks after a command.
// Backpressure: cmd_ready low while in dead time or while disabled.
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int R           = 8,
    parameter int DEAD_CYCLES = 100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [31:0]  tick_div,
    input  logic [R-1:0] step,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [R+1:0] cmd_speed,
    output logic [R:0]   duty,
    output logic         dir,
    output logic         at_target
);

    localparam logic [R:0] FULL = (R+1)'(duty_full(R));
    localparam int         CW   = $clog2(DEAD_CYCLES + 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

    ramp_state_t   state, state_nxt;
    logic [R:0]    duty_nxt;
    logic          dir_nxt;
    logic [CW-1:0] dead_cnt, dead_cnt_nxt;
    logic [R:0]    target_mag;
    logic          target_dir;
    logic          tick;
    logic          cmd_take;
    logic [R+1:0]  cmd_abs;
    logic [R:0]    cmd_mag;
    logic [R:0]    run_duty;
    logic [R:0]    zero_duty;
    logic          dir_mismatch;
    logic          target_ok;

    ramp_tick_gen u_tick (
        .clk      (clk),
        .reset    (reset),
        .clr      (!enable),
        .tick_div (tick_div),
        .tick     (tick)
    );

    assign cmd_ready = enable && (state != DEAD);
    assign cmd_take  = cmd_valid && cmd_ready;

    // Magnitude in R+2 bits: negating the most-negative code yields 2^(R+1), which then clamps.
    assign cmd_abs = cmd_speed[R+1] ? (~cmd_speed + (R+2)'(1)) : cmd_speed;
    assign cmd_mag = (cmd_abs > (R+2)'(FULL)) ? FULL : cmd_abs[R:0];

    assign run_duty  = (duty < target_mag)
                     ? (R+1)'(sat_up(32'(duty), 32'(step), 32'(target_mag)))
                     : (R+1)'(sat_dn(32'(duty), 32'(step), 32'(target_mag)));
    assign zero_duty = (R+1)'(sat_dn(32'(duty), 32'(step), 32'(0)));

    assign dir_mismatch = (target_mag != '0) && (target_dir != dir);
    assign target_ok    = (target_dir == dir) || (target_mag == '0);
    assign at_target    = (state == RUN) && (duty == target_mag) && target_ok;

    // Next-state and duty/dir decode; disable overrides everything but reset.
    always_comb begin
        state_nxt    = state;
        duty_nxt     = duty;
        dir_nxt      = dir;
        dead_cnt_nxt = dead_cnt;
        case (state)
            RUN: begin
                if (dir_mismatch) begin
                    state_nxt = RAMP_DN;
                    if (tick) duty_nxt = zero_duty;
                end else if (tick) begin
                    duty_nxt = run_duty;
                end
            end
            RAMP_DN: begin
                if (target_ok) begin
                    state_nxt = RUN;
                    if (tick) duty_nxt = run_duty;
                end else if (duty == '0) begin
                    state_nxt    = DEAD;
                    dead_cnt_nxt = '0;
                end else if (tick) begin
                    duty_nxt = zero_duty;
                end
            end
            DEAD: begin
                duty_nxt = '0;
                if (dead_cnt == DEAD_LAST) begin
                    dir_nxt   = target_dir;
                    state_nxt = RUN;
                end else begin
                    dead_cnt_nxt = dead_cnt + CW'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
        if (!enable) begin
            state_nxt = RUN;
            duty_nxt  = '0;
            dir_nxt   = dir;
        end
    end

    // FSM, duty and direction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            duty     <= '0;
            dir      <= 1'b0;
            dead_cnt <= '0;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            dir      <= dir_nxt;
            dead_cnt <= dead_cnt_nxt;
        end
    end

    // Target latch: accepted commands replace any pending target; disable clears magnitude.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_mag <= '0;
            target_dir <= 1'b0;
        end else if (!enable) begin
            target_mag <= '0;
        end else if (cmd_take) begin
            target_mag <= cmd_mag;
            target_dir <= cmd_speed[R+1];
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl (R=8, DEAD_CYCLES=4).
// Latency: expectations are queued per clock and compared 1 time unit after each rising edge.
// Backpressure: cmd_ready is part of every expected entry.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] tick_div;
    logic [7:0]  step;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_speed;
    logic [8:0]  duty;
    logic        dir;
    logic        at_target;

    typedef struct {
        logic [8:0] duty;
        logic       dir;
        logic       rdy;
        logic       at;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    step_idx = 0;
    string phase    = "init";

    pwm_ramp_ctrl #(.R(8), .DEAD_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .tick_div  (tick_div),
        .step      (step),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_speed (cmd_speed),
        .duty      (duty),
        .dir       (dir),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int d, input bit dr, input bit rd, input bit at);
        exp_t e;
        e.duty = 9'(d);
        e.dir  = dr;
        e.rdy  = rd;
        e.at   = at;
        sb.push_back(e);
    endtask

    // One clock: pop the expectation for this edge and compare all outputs.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({phase, ".sb_underflow"}, 1, 0);
        end else begin
            e = sb.pop_front();
            step_idx++;
            check($sformatf("%s[%0d].duty", phase, step_idx), int'(duty), int'(e.duty));
            check($sformatf("%s[%0d].dir", phase, step_idx), int'(dir), int'(e.dir));
            check($sformatf("%s[%0d].rdy", phase, step_idx), int'(cmd_ready), int'(e.rdy));
            check($sformatf("%s[%0d].at", phase, step_idx), int'(at_target), int'(e.at));
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) cycle();
    endtask

    task automatic start(input string name);
        phase    = name;
        step_idx = 0;
    endtask

    task automatic send_cmd(input logic [9:0] s);
        cmd_valid = 1'b1;
        cmd_speed = s;
        cycle();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1);
    end

    initial begin
        int d;
        reset     = 1'b0;
        enable    = 1'b1;
        tick_div  = 32'd0;
        step      = 8'd16;
        cmd_valid = 1'b0;
        cmd_speed = '0;

        // Reset values, visible before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset.duty", int'(duty), 0);
        check("reset.dir", int'(dir), 0);
        check("reset.rdy", int'(cmd_ready), 1);
        check("reset.at", int'(at_target), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // +128 from rest: one step per clock, at_target once 128 is reached.
        start("up128");
        push(0, 0, 1, 0);
        for (int c = 1; c <= 8; c++) push(16 * c, 0, 1, c == 8);
        push(128, 0, 1, 1);
        send_cmd(10'd128);
        drain();

        // -64 at +128: ramp to 0, 4 clocks of dead time, flip, ramp to 64.
        start("rev_m64");
        push(128, 0, 1, 0);
        for (int c = 1; c <= 8; c++) push(128 - 16 * c, 0, 1, 0);
        for (int c = 9; c <= 12; c++) push(0, 0, 0, 0);
        push(0, 1, 1, 0);
        for (int c = 14; c <= 17; c++) push(16 * (c - 13), 1, 1, c == 17);
        push(64, 1, 1, 1);
        send_cmd(10'(-64));
        drain();

        // Zero command: ramp down, keep reverse direction, no dead time.
        start("zero");
        push(64, 1, 1, 0);
        for (int c = 1; c <= 4; c++) push(64 - 16 * c, 1, 1, c == 4);
        send_cmd(10'd0);
        drain();

        // +100 with duty already 0 but dir reversed: dead time, then 16..96, 100.
        start("up100");
        push(0, 1, 1, 0);
        push(0, 1, 1, 0);
        for (int c = 2; c <= 5; c++) push(0, 1, 0, 0);
        push(0, 0, 1, 0);
        for (int c = 7; c <= 12; c++) push(16 * (c - 6), 0, 1, 0);
        push(100, 0, 1, 1);
        push(100, 0, 1, 1);
        send_cmd(10'd100);
        drain();

        // +80 below current duty: step down and stop exactly at 80.
        start("dn80");
        push(100, 0, 1, 0);
        push(84, 0, 1, 0);
        push(80, 0, 1, 1);
        push(80, 0, 1, 1);
        send_cmd(10'd80);
        drain();

        // Disable at duty 80; a command offered while disabled must be ignored.
        start("kill");
        enable    = 1'b0;
        cmd_valid = 1'b1;
        cmd_speed = 10'd50;
        push(0, 0, 0, 1);
        push(0, 0, 0, 1);
        cycle();
        cycle();
        cmd_valid = 1'b0;
        enable    = 1'b1;
        push(0, 0, 1, 1);
        cycle();

        start("reen32");
        push(0, 0, 1, 0);
        push(16, 0, 1, 0);
        push(32, 0, 1, 1);
        send_cmd(10'd32);
        drain();

        // -512 clamps to 256 reverse; tick_div=3 gives one step every 4th clock.
        start("kill2");
        enable = 1'b0;
        push(0, 0, 0, 1);
        cycle();
        enable   = 1'b1;
        tick_div = 32'd3;
        start("m512");
        push(0, 0, 1, 0);
        for (int c = 1; c <= 72; c++) begin
            d = (c < 7) ? 0 : 16 * ((c - 7) / 4 + 1);
            if (d > 256) d = 256;
            push(d, c >= 6, !(c >= 2 && c <= 5), d == 256);
        end
        send_cmd(10'(-512));
        drain();

        // Reverse again and hit reset in the middle of dead time.
        start("hold");
        tick_div = 32'd0;
        push(256, 1, 1, 1);
        cycle();
        start("rev16");
        push(256, 1, 1, 0);
        for (int c = 1; c <= 16; c++) push(256 - 16 * c, 1, 1, 0);
        push(0, 1, 0, 0);
        push(0, 1, 0, 0);
        send_cmd(10'd16);
        drain();
        #2 reset = 1'b1;
        #1;
        check("dead_reset.duty", int'(duty), 0);
        check("dead_reset.dir", int'(dir), 0);
        check("dead_reset.rdy", int'(cmd_ready), 1);
        check("dead_reset.at", int'(at_target), 1);
        #10 reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
